mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read memory between the instruction-fetch requester (I) and the load/store requester (D) of the RISC-V core.
- Issues at most one access per cycle. Data has priority, with a bounded-starvation guarantee for fetch.
- Read data returns one cycle after grant, tagged back to the owning requester.
- Sits between the core's fetch/memory stages and the unified program/data memory.

Parameters:
ADDR_W, 8, byte-address width on all address ports
DATA_W, 32, word width
STARVE_LIM, 4, max consecutive D grants while I is waiting before I is forced through (range 1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
i_req  in  1  fetch request, held until i_gnt
i_addr  in  ADDR_W  fetch address
i_gnt  out  1  fetch accepted this cycle
i_rvalid  out  1  fetch data valid
i_rdata  out  DATA_W  fetch data
i_stall  out  1  i_req & ~i_gnt
d_req  in  1  load/store request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  4  store byte enables
d_gnt  out  1  data access accepted this cycle
d_rvalid  out  1  load data valid
d_rdata  out  DATA_W  load data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wstrb  out  4  memory byte enables
mem_rdata  in  DATA_W  read data, valid the cycle after mem_en & ~mem_we

Behaviour:
- Arbitration is combinational from current requests and the registered streak counter. Grant and memory drive happen in the same cycle.
- Only one of i_gnt / d_gnt is asserted in any cycle.
- Priority rules:
  - Neither requests: no grant, mem_en = 0.
  - Only one requests: that requester wins.
  - Both request: D wins unless streak == STARVE_LIM, in which case I wins.
- Streak counter (registered, width clog2(STARVE_LIM+1)):
  - increments on a D grant while i_req = 1;
  - clears on any I grant, or any cycle with i_req = 0;
  - saturates at STARVE_LIM.
- Memory drive:
  - I grant: mem_en = 1, mem_we = 0, mem_addr = i_addr, mem_wstrb = 0.
  - D grant: mem_en = 1, mem_we = d_we, mem_addr = d_addr, mem_wdata = d_wdata, mem_wstrb = d_we ? d_wstrb : 0.
  - No grant: mem_en = 0, mem_we = 0, mem_addr/mem_wdata held at 0.
- Read return:
  - A 2-bit registered owner tag {i_rd, d_rd} is set on the grant cycle for reads only.
  - On the next cycle, exactly the tagged requester sees rvalid = 1 and rdata = mem_rdata. The untagged rdata is 0.
  - Stores produce no rvalid. Completion of a store is the d_gnt cycle.
- Back-to-back grants are legal every cycle, including alternating I/D. Each rvalid is independent, so there is no bubble.
- Requester rule: req, addr, we, wdata and wstrb must stay stable from assertion until gnt. Changing them before gnt is illegal; the arbiter samples the current value.
- Reset (rst = 1 at a clock edge):
  - owner tag = 0, streak = 0.
  - All outputs read 0 while rst is high: grants, rvalids, mem_en gated off.
  - An outstanding read whose rvalid would fall in the cycle after reset is dropped.
- Boundaries:
  - ADDR_W address wraps naturally; no range check.
  - STARVE_LIM = 1 gives strict alternation under continuous contention.

Test Plan:
- Fetch only, i_addr = 0x04 held, mem word = 32'h00218133 → i_gnt same cycle; next cycle i_rvalid = 1, i_rdata = 32'h00218133, d_rvalid = 0.
- Simultaneous i_req/d_req (load 0x40) → d_gnt = 1, i_gnt = 0, i_stall = 1; next cycle d_rvalid with the 0x40 data, and I is granted that cycle (d_req dropped).
- Store d_we = 1, d_wstrb = 4'b0011, d_wdata = 32'hDEADBEEF, addr 0x10 → mem_we = 1, mem_wstrb = 4'b0011 on the grant cycle; no d_rvalid follows; a later load of 0x10 returns low half BEEF.
- Continuous d_req and i_req, STARVE_LIM = 4 → grant sequence D,D,D,D,I,D,D,D,D,I…; I never waits more than 4 cycles.
- Alternating I read / D read every cycle for 8 cycles → each rvalid pulses exactly one cycle after its own grant; no cross-tagged data.
- Read granted at cycle N, rst = 1 at cycle N+1 → no rvalid at N+1 or later; streak = 0; all outputs 0 during reset; normal operation resumes on the first cycle after rst falls.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_port_arbiter: shares one synchronous-read memory port between fetch (I) |
// | and load/store (D); D has priority, I is forced through after a D streak.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic              clk,
   input  logic              rst,
   // fetch requester
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_stall,
   // load/store requester
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   // memory port
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int                  c_streak_w   = $clog2(STARVE_LIM + 1);
   localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(STARVE_LIM);
   localparam logic [c_streak_w-1:0] c_streak_one = c_streak_w'(1);

   logic [c_streak_w-1:0] streak_q, streak_d;
   logic                  i_rd_q, i_rd_d;
   logic                  d_rd_q, d_rd_d;
   logic                  sel_i, sel_d;
   logic                  i_starved;

   // D wins contention unless fetch has already lost STARVE_LIM times in a row
   always_comb begin
      sel_i     = 1'b0;
      sel_d     = 1'b0;
      i_starved = i_req && (streak_q == c_streak_max);
      if (!rst) begin
         if (d_req && !i_starved) begin
            sel_d = 1'b1;
         end else if (i_req) begin
            sel_i = 1'b1;
         end
      end
   end

   always_comb begin
      streak_d = '0;
      if (sel_d && i_req) begin
         streak_d = (streak_q == c_streak_max) ? c_streak_max : streak_q + c_streak_one;
      end
   end

   // owner tag only for reads; stores complete on their grant cycle
   always_comb begin
      i_rd_d = sel_i;
      d_rd_d = sel_d && !d_we;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         streak_q <= '0;
         i_rd_q   <= 1'b0;
         d_rd_q   <= 1'b0;
      end else begin
         streak_q <= streak_d;
         i_rd_q   <= i_rd_d;
         d_rd_q   <= d_rd_d;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      mem_wstrb = 4'b0000;
      if (sel_i) begin
         mem_en   = 1'b1;
         mem_addr = i_addr;
      end else if (sel_d) begin
         mem_en    = 1'b1;
         mem_we    = d_we;
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
         mem_wstrb = d_we ? d_wstrb : 4'b0000;
      end
   end

   // reset masks any read return still in flight
   always_comb begin
      i_gnt    = sel_i;
      d_gnt    = sel_d;
      i_stall  = i_req && !sel_i && !rst;
      i_rvalid = i_rd_q && !rst;
      d_rvalid = d_rd_q && !rst;
      i_rdata  = i_rvalid ? mem_rdata : '0;
      d_rdata  = d_rvalid ? mem_rdata : '0;
   end

endmodule
`default_nettype wire
